// File: rtl/imem_pkg.sv
// Shared constants and helpers for the dual-read instruction memory.
// Helpers work on the widest supported word; callers cast to XLEN.
package imem_pkg;

  localparam int MAX_XLEN  = 64;
  localparam int MAX_BYTES = MAX_XLEN / 8;

  // addi x0, x0, 0, zero-extended to the widest word
  localparam logic [MAX_XLEN-1:0] NOP_INSTR = 64'h0000_0000_0000_0013;

  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input int unsigned shift);
    return addr >> shift;
  endfunction

  // Old word with each byte enabled by mask replaced by the matching wdata byte
  function automatic logic [MAX_XLEN-1:0] merge_bytes(input logic [MAX_XLEN-1:0]  old_word,
                                                      input logic [MAX_XLEN-1:0]  wdata,
                                                      input logic [MAX_BYTES-1:0] mask);
    logic [MAX_XLEN-1:0] res;
    res = old_word;
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (mask[b]) begin
        res[b*8 +: 8] = wdata[b*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/imem_rd_pipe.sv
// Per-port read pipeline: one or two register stages tracking data, valid and
// error, all frozen while pause is high.
module imem_rd_pipe
  import imem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int OUT_REG = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pause,
  input  logic            req,
  input  logic            in_range,
  input  logic [XLEN-1:0] rd_word,
  output logic [XLEN-1:0] rdata,
  output logic            valid,
  output logic            err
);

  localparam logic [XLEN-1:0] NOP_W = XLEN'(NOP_INSTR);

  logic [XLEN-1:0] s1_data_reg;
  logic            s1_valid_reg;
  logic            s1_err_reg;

  // Data and err only move on a request so an idle port keeps its last result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data_reg  <= NOP_W;
      s1_valid_reg <= 1'b0;
      s1_err_reg   <= 1'b0;
    end else if (!pause) begin
      s1_valid_reg <= req;
      if (req) begin
        s1_data_reg <= in_range ? rd_word : NOP_W;
        s1_err_reg  <= !in_range;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [XLEN-1:0] s2_data_reg;
      logic            s2_valid_reg;
      logic            s2_err_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_data_reg  <= NOP_W;
          s2_valid_reg <= 1'b0;
          s2_err_reg   <= 1'b0;
        end else if (!pause) begin
          s2_data_reg  <= s1_data_reg;
          s2_valid_reg <= s1_valid_reg;
          s2_err_reg   <= s1_err_reg;
        end
      end

      assign rdata = s2_data_reg;
      assign valid = s2_valid_reg;
      assign err   = s2_err_reg;
    end else begin : g_direct
      assign rdata = s1_data_reg;
      assign valid = s1_valid_reg;
      assign err   = s1_err_reg;
    end
  endgenerate

endmodule

// File: rtl/instr_mem_dp.sv
// Dual-read instruction memory: fetch port, branch-predict lookahead port and a
// byte-masked write port with write-first forwarding into both reads.
module instr_mem_dp
  import imem_pkg::*;
#(
  parameter     MEM_FILE = "",
  parameter int DEPTH    = 1024,
  parameter int XLEN     = 32,
  parameter int OUT_REG  = 0,
  parameter int PRED_EN  = 1,
  parameter int WR_EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              l_pause,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic [XLEN-1:0]   f_rdata,
  output logic              f_valid,
  output logic              f_err,
  input  logic              p_req,
  input  logic [31:0]       p_addr,
  output logic [XLEN-1:0]   p_rdata,
  output logic              p_valid,
  input  logic              w_en,
  input  logic [31:0]       w_addr,
  input  logic [XLEN/8-1:0] w_mask,
  input  logic [XLEN-1:0]   w_wdata
);

  localparam int          BYTES = XLEN / 8;
  localparam int unsigned SHIFT = $clog2(BYTES);
  localparam int          IDX_W = $clog2(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];

  logic [31:0]      f_wi, p_wi, w_wi;
  logic [IDX_W-1:0] f_idx, p_idx, w_idx;
  logic             f_in_range, p_in_range, w_in_range;
  logic             w_fire;

  assign f_wi = word_index(f_addr, SHIFT);
  assign p_wi = word_index(p_addr, SHIFT);
  assign w_wi = word_index(w_addr, SHIFT);

  assign f_idx = f_wi[IDX_W-1:0];
  assign p_idx = p_wi[IDX_W-1:0];
  assign w_idx = w_wi[IDX_W-1:0];

  assign f_in_range = (f_wi < 32'(DEPTH));
  assign p_in_range = (p_wi < 32'(DEPTH));
  assign w_in_range = (w_wi < 32'(DEPTH));

  // Out-of-range writes are dropped rather than aliased onto low words
  assign w_fire = (WR_EN != 0) && w_en && w_in_range;

  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int b = 0; b < BYTES; b++) begin
        if (w_mask[b]) begin
          mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Write-first view of a word: a same-cycle write to it is merged in
  logic [XLEN-1:0] w_merged_f, w_merged_p;
  logic [XLEN-1:0] f_word, p_word;

  assign w_merged_f = XLEN'(merge_bytes(MAX_XLEN'(mem[f_idx]), MAX_XLEN'(w_wdata),
                                        MAX_BYTES'(w_mask)));
  assign w_merged_p = XLEN'(merge_bytes(MAX_XLEN'(mem[p_idx]), MAX_XLEN'(w_wdata),
                                        MAX_BYTES'(w_mask)));

  assign f_word = (w_fire && (w_idx == f_idx)) ? w_merged_f : mem[f_idx];
  assign p_word = (w_fire && (w_idx == p_idx)) ? w_merged_p : mem[p_idx];

  imem_rd_pipe #(
    .XLEN    (XLEN),
    .OUT_REG (OUT_REG)
  ) u_fetch_pipe (
    .clk      (clk),
    .rst      (rst),
    .pause    (l_pause),
    .req      (f_req),
    .in_range (f_in_range),
    .rd_word  (f_word),
    .rdata    (f_rdata),
    .valid    (f_valid),
    .err      (f_err)
  );

  generate
    if (PRED_EN != 0) begin : g_pred
      logic p_err_unused;

      imem_rd_pipe #(
        .XLEN    (XLEN),
        .OUT_REG (OUT_REG)
      ) u_pred_pipe (
        .clk      (clk),
        .rst      (rst),
        .pause    (1'b0),
        .req      (p_req),
        .in_range (p_in_range),
        .rd_word  (p_word),
        .rdata    (p_rdata),
        .valid    (p_valid),
        .err      (p_err_unused)
      );
    end else begin : g_no_pred
      logic unused_pred;

      assign unused_pred = ^{p_req, p_in_range, p_word};
      assign p_rdata     = XLEN'(NOP_INSTR);
      assign p_valid     = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_instr_mem_dp.sv
// Bench for instr_mem_dp: a 1-cycle DUT (predict on) and a 2-cycle DUT
// (predict off) share stimulus; expectations queue up per port and are popped on output.
module tb_instr_mem_dp;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] NOP32 = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        l_pause, f_req, p_req, w_en;
  logic [31:0] f_addr, p_addr, w_addr, w_wdata;
  logic [3:0]  w_mask;

  logic [31:0] a_f_rdata, a_p_rdata, b_f_rdata, b_p_rdata;
  logic        a_f_valid, a_f_err, a_p_valid, b_f_valid, b_f_err, b_p_valid;

  instr_mem_dp #(
    .MEM_FILE (""), .DEPTH (DEPTH), .XLEN (32), .OUT_REG (0), .PRED_EN (1), .WR_EN (1)
  ) dut_a (
    .clk (clk), .rst (rst), .l_pause (l_pause),
    .f_req (f_req), .f_addr (f_addr), .f_rdata (a_f_rdata), .f_valid (a_f_valid), .f_err (a_f_err),
    .p_req (p_req), .p_addr (p_addr), .p_rdata (a_p_rdata), .p_valid (a_p_valid),
    .w_en (w_en), .w_addr (w_addr), .w_mask (w_mask), .w_wdata (w_wdata)
  );

  instr_mem_dp #(
    .MEM_FILE (""), .DEPTH (DEPTH), .XLEN (32), .OUT_REG (1), .PRED_EN (0), .WR_EN (1)
  ) dut_b (
    .clk (clk), .rst (rst), .l_pause (l_pause),
    .f_req (f_req), .f_addr (f_addr), .f_rdata (b_f_rdata), .f_valid (b_f_valid), .f_err (b_f_err),
    .p_req (p_req), .p_addr (p_addr), .p_rdata (b_p_rdata), .p_valid (b_p_valid),
    .w_en (w_en), .w_addr (w_addr), .w_mask (w_mask), .w_wdata (w_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        qp[$];
  exp_t        e;
  logic [31:0] model [DEPTH];
  int          vectors     = 0;
  int          miscompares = 0;

  function automatic logic [31:0] img_word(input int i);
    if (i == 0) return 32'h0050_0093;
    if (i == 3) return 32'h1122_3344;
    return 32'h0A00_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  // Reference read including write-first merge of any write driven this cycle
  function automatic exp_t exp_of(input logic [31:0] addr);
    exp_t        r;
    logic [31:0] idx;
    logic [31:0] widx;
    idx  = addr >> 2;
    widx = w_addr >> 2;
    if (idx >= 32'(DEPTH)) begin
      r.data = NOP32;
      r.err  = 1'b1;
    end else begin
      r.data = model[idx[9:0]];
      r.err  = 1'b0;
      if (w_en && (widx < 32'(DEPTH)) && (widx == idx)) begin
        for (int b = 0; b < 4; b++) begin
          if (w_mask[b]) r.data[b*8 +: 8] = w_wdata[b*8 +: 8];
        end
      end
    end
    return r;
  endfunction

  task automatic tick();
    logic [31:0] widx;
    @(posedge clk);
    widx = w_addr >> 2;
    if (w_en && (widx < 32'(DEPTH))) begin
      for (int b = 0; b < 4; b++) begin
        if (w_mask[b]) model[widx[9:0]][b*8 +: 8] = w_wdata[b*8 +: 8];
      end
    end
    #1;
  endtask

  task automatic issue_fetch(input logic [31:0] addr);
    exp_t x;
    x = exp_of(addr);
    f_req  = 1'b1;
    f_addr = addr;
    qa.push_back(x);
    qb.push_back(x);
    $display("txn fetch addr=%h expect data=%h err=%0b", addr, x.data, x.err);
  endtask

  task automatic issue_pred(input logic [31:0] addr);
    p_req  = 1'b1;
    p_addr = addr;
    qp.push_back(exp_of(addr));
  endtask

  task automatic load_image();
    for (int i = 0; i < 16; i++) begin
      w_en = 1'b1; w_addr = 32'(i * 4); w_mask = 4'hF; w_wdata = img_word(i);
      tick();
    end
    w_en = 1'b0;
  endtask

  task automatic test_reset();
    issue_fetch(32'h4);
    tick();
    e = qa.pop_front();
    vectors++; if (a_f_rdata !== e.data) begin miscompares++; $display("FAIL pre_reset_a_data got=%h exp=%h", a_f_rdata, e.data); end
    rst = 1'b1;
    #2;
    vectors++; if (a_f_rdata !== NOP32) begin miscompares++; $display("FAIL reset_a_data got=%h exp=%h", a_f_rdata, NOP32); end
    vectors++; if (a_f_valid !== 1'b0) begin miscompares++; $display("FAIL reset_a_valid got=%b exp=0", a_f_valid); end
    vectors++; if (a_f_err !== 1'b0) begin miscompares++; $display("FAIL reset_a_err got=%b exp=0", a_f_err); end
    vectors++; if (b_f_rdata !== NOP32) begin miscompares++; $display("FAIL reset_b_data got=%h exp=%h", b_f_rdata, NOP32); end
    vectors++; if (b_f_valid !== 1'b0) begin miscompares++; $display("FAIL reset_b_valid got=%b exp=0", b_f_valid); end
    vectors++; if (a_p_rdata !== NOP32) begin miscompares++; $display("FAIL reset_a_pdata got=%h exp=%h", a_p_rdata, NOP32); end
    tick();
    tick();
    rst = 1'b0;
    f_req = 1'b0;
    qa.delete();
    qb.delete();
    tick();
    vectors++; if (a_f_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_a_valid got=%b exp=0", a_f_valid); end
    vectors++; if (b_f_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_b_valid got=%b exp=0", b_f_valid); end
    issue_fetch(32'h0);
    tick();
    f_req = 1'b0;
    e = qa.pop_front();
    vectors++; if (a_f_rdata !== 32'h0050_0093) begin miscompares++; $display("FAIL first_a_data got=%h exp=%h", a_f_rdata, 32'h0050_0093); end
    vectors++; if (a_f_valid !== 1'b1) begin miscompares++; $display("FAIL first_a_valid got=%b exp=1", a_f_valid); end
    vectors++; if (b_f_valid !== 1'b0) begin miscompares++; $display("FAIL first_b_early_valid got=%b exp=0", b_f_valid); end
    tick();
    e = qb.pop_front();
    vectors++; if (b_f_rdata !== e.data) begin miscompares++; $display("FAIL first_b_data got=%h exp=%h", b_f_rdata, e.data); end
    vectors++; if (b_f_valid !== 1'b1) begin miscompares++; $display("FAIL first_b_valid got=%b exp=1", b_f_valid); end
    vectors++; if (a_f_valid !== 1'b0) begin miscompares++; $display("FAIL idle_a_valid got=%b exp=0", a_f_valid); end
    vectors++; if (a_f_rdata !== 32'h0050_0093) begin miscompares++; $display("FAIL idle_a_hold got=%h exp=%h", a_f_rdata, 32'h0050_0093); end
  endtask

  task automatic test_pause();
    logic [31:0] word1;
    word1 = model[1];
    issue_fetch(32'h4);
    tick();
    e = qa.pop_front();
    vectors++; if (a_f_rdata !== e.data) begin miscompares++; $display("FAIL pause_pre_a_data got=%h exp=%h", a_f_rdata, e.data); end
    l_pause = 1'b1;
    f_req   = 1'b1;
    f_addr  = 32'h8;
    for (int c = 0; c < 3; c++) begin
      issue_pred(32'h8);
      tick();
      e = qp.pop_front();
      vectors++; if (a_f_rdata !== word1) begin miscompares++; $display("FAIL pause_a_data c=%0d got=%h exp=%h", c, a_f_rdata, word1); end
      vectors++; if (a_f_valid !== 1'b1) begin miscompares++; $display("FAIL pause_a_valid c=%0d got=%b exp=1", c, a_f_valid); end
      vectors++; if (b_f_valid !== 1'b0) begin miscompares++; $display("FAIL pause_b_valid c=%0d got=%b exp=0", c, b_f_valid); end
      vectors++; if (a_p_rdata !== e.data) begin miscompares++; $display("FAIL pause_a_pdata c=%0d got=%h exp=%h", c, a_p_rdata, e.data); end
      vectors++; if (a_p_valid !== 1'b1) begin miscompares++; $display("FAIL pause_a_pvalid c=%0d got=%b exp=1", c, a_p_valid); end
      vectors++; if (b_p_valid !== 1'b0 || b_p_rdata !== NOP32) begin miscompares++; $display("FAIL nopred_b c=%0d got=%b/%h exp=0/%h", c, b_p_valid, b_p_rdata, NOP32); end
    end
    l_pause = 1'b0;
    f_req   = 1'b0;
    p_req   = 1'b0;
    tick();
    e = qb.pop_front();
    vectors++; if (b_f_rdata !== e.data || b_f_valid !== 1'b1) begin miscompares++; $display("FAIL unpause_b got=%h/%b exp=%h/1", b_f_rdata, b_f_valid, e.data); end
    vectors++; if (a_f_valid !== 1'b0 || a_f_rdata !== word1) begin miscompares++; $display("FAIL unpause_a got=%h/%b exp=%h/0", a_f_rdata, a_f_valid, word1); end
    vectors++; if (a_p_valid !== 1'b0) begin miscompares++; $display("FAIL unpause_a_pvalid got=%b exp=0", a_p_valid); end
    tick();
    vectors++; if (b_f_valid !== 1'b0) begin miscompares++; $display("FAIL unpause_b_idle got=%b exp=0", b_f_valid); end
  endtask

  task automatic test_forward();
    w_en = 1'b1; w_addr = 32'd12; w_mask = 4'b0101; w_wdata = 32'hAABB_CCDD;
    issue_pred(32'd12);
    issue_fetch(32'd12);
    tick();
    w_en  = 1'b0;
    p_req = 1'b0;
    e = qa.pop_front();
    vectors++; if (a_f_rdata !== 32'h11BB_33DD) begin miscompares++; $display("FAIL fwd_a_data got=%h exp=%h", a_f_rdata, 32'h11BB_33DD); end
    vectors++; if (a_f_rdata !== e.data) begin miscompares++; $display("FAIL fwd_a_model got=%h exp=%h", a_f_rdata, e.data); end
    e = qp.pop_front();
    vectors++; if (a_p_rdata !== e.data || a_p_valid !== 1'b1) begin miscompares++; $display("FAIL fwd_a_pred got=%h/%b exp=%h/1", a_p_rdata, a_p_valid, e.data); end
    issue_fetch(32'd12);
    tick();
    f_req = 1'b0;
    e = qa.pop_front();
    vectors++; if (a_f_rdata !== e.data) begin miscompares++; $display("FAIL later_a_data got=%h exp=%h", a_f_rdata, e.data); end
    e = qb.pop_front();
    vectors++; if (b_f_rdata !== e.data || b_f_valid !== 1'b1) begin miscompares++; $display("FAIL fwd_b got=%h/%b exp=%h/1", b_f_rdata, b_f_valid, e.data); end
    tick();
    e = qb.pop_front();
    vectors++; if (b_f_rdata !== e.data) begin miscompares++; $display("FAIL later_b_data got=%h exp=%h", b_f_rdata, e.data); end
  endtask

  task automatic test_out_of_range();
    issue_fetch(32'h1000);
    tick();
    e = qa.pop_front();
    vectors++; if (a_f_rdata !== NOP32 || a_f_err !== 1'b1 || a_f_valid !== 1'b1) begin miscompares++; $display("FAIL oor_a got=%h/err%b/v%b exp=%h/err1/v1", a_f_rdata, a_f_err, a_f_valid, NOP32); end
    w_en = 1'b1; w_addr = 32'h1000; w_mask = 4'hF; w_wdata = 32'hDEAD_BEEF;
    issue_fetch(32'h0);
    tick();
    w_en = 1'b0;
    e = qa.pop_front();
    vectors++; if (a_f_rdata !== e.data || a_f_err !== 1'b0) begin miscompares++; $display("FAIL oor_wr_same_a got=%h/err%b exp=%h/err0", a_f_rdata, a_f_err, e.data); end
    e = qb.pop_front();
    vectors++; if (b_f_rdata !== NOP32 || b_f_err !== 1'b1) begin miscompares++; $display("FAIL oor_b got=%h/err%b exp=%h/err1", b_f_rdata, b_f_err, NOP32); end
    issue_fetch(32'h0);
    tick();
    f_req = 1'b0;
    e = qa.pop_front();
    vectors++; if (a_f_rdata !== 32'h0050_0093) begin miscompares++; $display("FAIL oor_wr_drop_a got=%h exp=%h", a_f_rdata, 32'h0050_0093); end
    e = qb.pop_front();
    vectors++; if (b_f_rdata !== e.data || b_f_err !== 1'b0) begin miscompares++; $display("FAIL oor_next_b got=%h/err%b exp=%h/err0", b_f_rdata, b_f_err, e.data); end
    tick();
    e = qb.pop_front();
    vectors++; if (b_f_rdata !== 32'h0050_0093) begin miscompares++; $display("FAIL oor_wr_drop_b got=%h exp=%h", b_f_rdata, 32'h0050_0093); end
  endtask

  task automatic test_concurrent();
    issue_pred(32'h20);
    issue_fetch(32'h20);
    tick();
    f_req = 1'b0;
    p_req = 1'b0;
    e = qa.pop_front();
    vectors++; if (a_f_rdata !== e.data || a_f_valid !== 1'b1) begin miscompares++; $display("FAIL conc_a_f got=%h/%b exp=%h/1", a_f_rdata, a_f_valid, e.data); end
    e = qp.pop_front();
    vectors++; if (a_p_rdata !== e.data || a_p_valid !== 1'b1) begin miscompares++; $display("FAIL conc_a_p got=%h/%b exp=%h/1", a_p_rdata, a_p_valid, e.data); end
    vectors++; if (b_p_valid !== 1'b0 || b_p_rdata !== NOP32) begin miscompares++; $display("FAIL conc_b_nopred got=%b/%h exp=0/%h", b_p_valid, b_p_rdata, NOP32); end
    tick();
    e = qb.pop_front();
    vectors++; if (b_f_rdata !== e.data || b_f_valid !== 1'b1) begin miscompares++; $display("FAIL conc_b_f got=%h/%b exp=%h/1", b_f_rdata, b_f_valid, e.data); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) issue_fetch(32'(i * 4));
      else f_req = 1'b0;
      tick();
      if (i < 16) begin
        e = qa.pop_front();
        vectors++; if (a_f_rdata !== e.data || a_f_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_a i=%0d got=%h/%b exp=%h/1", i, a_f_rdata, a_f_valid, e.data); end
      end
      if (i >= 1) begin
        e = qb.pop_front();
        vectors++; if (b_f_rdata !== e.data || b_f_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_b i=%0d got=%h/%b exp=%h/1", i, b_f_rdata, b_f_valid, e.data); end
      end
    end
    tick();
    vectors++; if (b_f_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_b_drain got=%b exp=0", b_f_valid); end
    vectors++; if (qb.size() != 0) begin miscompares++; $display("FAIL b2b_b_leftover got=%0d exp=0", qb.size()); end
  endtask

  initial begin
    rst = 1'b1; l_pause = 1'b0; f_req = 1'b0; p_req = 1'b0; w_en = 1'b0;
    f_addr = '0; p_addr = '0; w_addr = '0; w_mask = '0; w_wdata = '0;
    tick();
    tick();
    rst = 1'b0;
    load_image();
    test_reset();
    test_pause();
    test_forward();
    test_out_of_range();
    test_concurrent();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
